// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS controller and datapath ALU control.
package mips_ctrl_pkg;

  localparam int unsigned STATE_W  = 4;
  localparam int unsigned OPCODE_W = 6;
  localparam int unsigned SEL_W    = 2;

  localparam logic [OPCODE_W-1:0] OP_RTYPE = 6'h00;
  localparam logic [OPCODE_W-1:0] OP_LW    = 6'h23;
  localparam logic [OPCODE_W-1:0] OP_SW    = 6'h2B;
  localparam logic [OPCODE_W-1:0] OP_BEQ   = 6'h04;
  localparam logic [OPCODE_W-1:0] OP_ADDI  = 6'h08;
  localparam logic [OPCODE_W-1:0] OP_J     = 6'h02;

  typedef enum logic [STATE_W-1:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11
  } stateT;

  localparam logic [SEL_W-1:0] SRCB_B     = 2'b00;
  localparam logic [SEL_W-1:0] SRCB_FOUR  = 2'b01;
  localparam logic [SEL_W-1:0] SRCB_IMM   = 2'b10;
  localparam logic [SEL_W-1:0] SRCB_IMMSH = 2'b11;

  localparam logic [SEL_W-1:0] ALUOP_ADD   = 2'b00;
  localparam logic [SEL_W-1:0] ALUOP_SUB   = 2'b01;
  localparam logic [SEL_W-1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [SEL_W-1:0] PCSRC_ALU    = 2'b00;
  localparam logic [SEL_W-1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [SEL_W-1:0] PCSRC_JUMP   = 2'b10;

  // Full set of datapath controls driven by the FSM
  typedef struct packed {
    logic             iorD;
    logic             memRead;
    logic             memWrite;
    logic             irWrite;
    logic             regDst;
    logic             memtoReg;
    logic             regWrite;
    logic             aluSrcA;
    logic [SEL_W-1:0] aluSrcB;
    logic [SEL_W-1:0] aluOp;
    logic [SEL_W-1:0] pcSrc;
    logic             pcWrite;
    logic             branch;
  } ctrlT;

endpackage

// File: rtl/control_output_decode.sv
// Moore output decoder: current state plus memory handshake to datapath controls.
module control_output_decode
  import mips_ctrl_pkg::*;
(
  input  logic [STATE_W-1:0] state,
  input  logic               memReady,
  output ctrlT               ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.memRead = 1'b1;
        ctrl.aluSrcB = SRCB_FOUR;
        ctrl.aluOp   = ALUOP_ADD;
        ctrl.pcSrc   = PCSRC_ALU;
        // IR and PC update together on the cycle the fetch completes
        ctrl.irWrite = memReady;
        ctrl.pcWrite = memReady;
      end
      S_DECODE: begin
        ctrl.aluSrcB = SRCB_IMMSH;
        ctrl.aluOp   = ALUOP_ADD;
      end
      S_MEMADR: begin
        ctrl.aluSrcA = 1'b1;
        ctrl.aluSrcB = SRCB_IMM;
        ctrl.aluOp   = ALUOP_ADD;
      end
      S_MEMRD: begin
        ctrl.memRead = 1'b1;
        ctrl.iorD    = 1'b1;
      end
      S_MEMWB: begin
        ctrl.memtoReg = 1'b1;
        ctrl.regWrite = 1'b1;
      end
      S_MEMWR: begin
        ctrl.iorD     = 1'b1;
        // Strobe only on the completing cycle so each sw writes exactly once
        ctrl.memWrite = memReady;
      end
      S_EXEC: begin
        ctrl.aluSrcA = 1'b1;
        ctrl.aluSrcB = SRCB_B;
        ctrl.aluOp   = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        ctrl.regDst   = 1'b1;
        ctrl.regWrite = 1'b1;
      end
      S_BRANCH: begin
        ctrl.aluSrcA = 1'b1;
        ctrl.aluSrcB = SRCB_B;
        ctrl.aluOp   = ALUOP_SUB;
        ctrl.pcSrc   = PCSRC_ALUOUT;
        ctrl.branch  = 1'b1;
      end
      S_ADDIEX: begin
        ctrl.aluSrcA = 1'b1;
        ctrl.aluSrcB = SRCB_IMM;
        ctrl.aluOp   = ALUOP_ADD;
      end
      S_ADDIWB: begin
        ctrl.regWrite = 1'b1;
      end
      S_JUMP: begin
        ctrl.pcSrc   = PCSRC_JUMP;
        ctrl.pcWrite = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Main controller FSM for the multicycle MIPS datapath: state register,
// next-state logic and the sticky illegal-opcode flag.
module multicycle_control
  import mips_ctrl_pkg::*;
(
  input  logic                Clk,
  input  logic                Rst_n,
  input  logic [OPCODE_W-1:0] Opcode,
  input  logic                MemReady,
  output logic                IorD,
  output logic                MemRead,
  output logic                MemWrite,
  output logic                IRWrite,
  output logic                RegDst,
  output logic                MemtoReg,
  output logic                RegWrite,
  output logic                ALUSrcA,
  output logic [SEL_W-1:0]    ALUSrcB,
  output logic [SEL_W-1:0]    ALUOp,
  output logic [SEL_W-1:0]    PCSrc,
  output logic                PCWrite,
  output logic                Branch,
  output logic                IllegalOp,
  output logic [STATE_W-1:0]  State
);

  logic [STATE_W-1:0] stateQ;
  logic [STATE_W-1:0] stateD;
  logic               illegalQ;
  logic               illegalD;
  ctrlT               ctrl;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      stateQ   <= S_FETCH;
      illegalQ <= 1'b0;
    end else begin
      stateQ   <= stateD;
      illegalQ <= illegalD;
    end
  end

  // Opcode only influences the DECODE and MEMADR transitions
  always_comb begin
    stateD   = S_FETCH;
    illegalD = illegalQ;
    case (stateQ)
      S_FETCH:  stateD = MemReady ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (Opcode)
          OP_LW, OP_SW: stateD = S_MEMADR;
          OP_RTYPE:     stateD = S_EXEC;
          OP_BEQ:       stateD = S_BRANCH;
          OP_ADDI:      stateD = S_ADDIEX;
          OP_J:         stateD = S_JUMP;
          default: begin
            stateD   = S_FETCH;
            illegalD = 1'b1;
          end
        endcase
      end
      S_MEMADR: stateD = (Opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  stateD = MemReady ? S_MEMWB : S_MEMRD;
      S_MEMWB:  stateD = S_FETCH;
      S_MEMWR:  stateD = MemReady ? S_FETCH : S_MEMWR;
      S_EXEC:   stateD = S_ALUWB;
      S_ALUWB:  stateD = S_FETCH;
      S_BRANCH: stateD = S_FETCH;
      S_ADDIEX: stateD = S_ADDIWB;
      S_ADDIWB: stateD = S_FETCH;
      S_JUMP:   stateD = S_FETCH;
      default:  stateD = S_FETCH;
    endcase
  end

  control_output_decode uDecode (
    .state    (stateQ),
    .memReady (MemReady),
    .ctrl     (ctrl)
  );

  assign IorD      = ctrl.iorD;
  assign MemRead   = ctrl.memRead;
  assign MemWrite  = ctrl.memWrite;
  assign IRWrite   = ctrl.irWrite;
  assign RegDst    = ctrl.regDst;
  assign MemtoReg  = ctrl.memtoReg;
  assign RegWrite  = ctrl.regWrite;
  assign ALUSrcA   = ctrl.aluSrcA;
  assign ALUSrcB   = ctrl.aluSrcB;
  assign ALUOp     = ctrl.aluOp;
  assign PCSrc     = ctrl.pcSrc;
  assign PCWrite   = ctrl.pcWrite;
  assign Branch    = ctrl.branch;
  assign IllegalOp = illegalQ;
  assign State     = stateQ;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: vector table, corner-case
// sequences and randomized instruction streams against a sequence model.
module tb_multicycle_control;

  localparam logic [5:0] LW   = 6'h23;
  localparam logic [5:0] SW   = 6'h2B;
  localparam logic [5:0] RT   = 6'h00;
  localparam logic [5:0] BEQ  = 6'h04;
  localparam logic [5:0] ADDI = 6'h08;
  localparam logic [5:0] JMP  = 6'h02;
  localparam logic [5:0] BAD  = 6'h3F;

  logic       Clk;
  logic       Rst_n;
  logic [5:0] Opcode;
  logic       MemReady;
  logic       IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite;
  logic       ALUSrcA, PCWrite, Branch, IllegalOp;
  logic [1:0] ALUSrcB, ALUOp, PCSrc;
  logic [3:0] State;

  multicycle_control dut (
    .Clk(Clk), .Rst_n(Rst_n), .Opcode(Opcode), .MemReady(MemReady),
    .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .RegDst(RegDst), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSrc(PCSrc),
    .PCWrite(PCWrite), .Branch(Branch), .IllegalOp(IllegalOp), .State(State)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int checks = 0;
  int errors = 0;

  logic [15:0] dutVec;
  assign dutVec = {IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
                   ALUSrcA, ALUSrcB, ALUOp, PCSrc, PCWrite, Branch};

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Control table written directly from the state descriptions
  function automatic logic [15:0] expOut(input int s, input logic mr);
    logic iord = 0, mrd = 0, mw = 0, irw = 0, rd = 0, mtr = 0, rw = 0, srcA = 0;
    logic pcw = 0, br = 0;
    logic [1:0] srcB = 2'b00, aop = 2'b00, pcs = 2'b00;
    case (s)
      0:  begin mrd = 1; srcB = 2'b01; irw = mr; pcw = mr; end
      1:  srcB = 2'b11;
      2:  begin srcA = 1; srcB = 2'b10; end
      3:  begin mrd = 1; iord = 1; end
      4:  begin mtr = 1; rw = 1; end
      5:  begin iord = 1; mw = mr; end
      6:  begin srcA = 1; aop = 2'b10; end
      7:  begin rd = 1; rw = 1; end
      8:  begin srcA = 1; aop = 2'b01; pcs = 2'b01; br = 1; end
      9:  begin srcA = 1; srcB = 2'b10; end
      10: rw = 1;
      11: begin pcs = 2'b10; pcw = 1; end
      default: ;
    endcase
    return {iord, mrd, mw, irw, rd, mtr, rw, srcA, srcB, aop, pcs, pcw, br};
  endfunction

  // Expected per-cycle stream: state, MemReady to drive, Opcode to drive, illegal-set
  int         qState[$];
  logic       qMr[$];
  logic [5:0] qOp[$];
  logic       qIll[$];
  logic       illExp;

  task automatic pushCycle(input int s, input logic mr, input logic [5:0] op, input logic ill);
    qState.push_back(s);
    qMr.push_back(mr);
    qOp.push_back(op);
    qIll.push_back(ill);
  endtask

  function automatic logic [5:0] junkOp();
    return 6'($urandom_range(0, 63));
  endfunction

  function automatic logic freeMr();
    return 1'($urandom_range(0, 1));
  endfunction

  // Instruction walk: fs fetch stalls, ms memory stalls, real Opcode only in DECODE/MEMADR
  task automatic buildSeq(input logic [5:0] op, input int fs, input int ms);
    logic legal;
    legal = (op == LW) || (op == SW) || (op == RT) || (op == BEQ) || (op == ADDI) || (op == JMP);
    for (int i = 0; i < fs; i++) pushCycle(0, 1'b0, junkOp(), 1'b0);
    pushCycle(0, 1'b1, junkOp(), 1'b0);
    pushCycle(1, freeMr(), op, !legal);
    if (op == LW) begin
      pushCycle(2, freeMr(), op, 1'b0);
      for (int i = 0; i < ms; i++) pushCycle(3, 1'b0, junkOp(), 1'b0);
      pushCycle(3, 1'b1, junkOp(), 1'b0);
      pushCycle(4, freeMr(), junkOp(), 1'b0);
    end else if (op == SW) begin
      pushCycle(2, freeMr(), op, 1'b0);
      for (int i = 0; i < ms; i++) pushCycle(5, 1'b0, junkOp(), 1'b0);
      pushCycle(5, 1'b1, junkOp(), 1'b0);
    end else if (op == RT) begin
      pushCycle(6, freeMr(), junkOp(), 1'b0);
      pushCycle(7, freeMr(), junkOp(), 1'b0);
    end else if (op == BEQ) begin
      pushCycle(8, freeMr(), junkOp(), 1'b0);
    end else if (op == ADDI) begin
      pushCycle(9, freeMr(), junkOp(), 1'b0);
      pushCycle(10, freeMr(), junkOp(), 1'b0);
    end else if (op == JMP) begin
      pushCycle(11, freeMr(), junkOp(), 1'b0);
    end
  endtask

  // Entered at posedge+1; leaves at posedge+1 after the last modelled cycle
  task automatic runSeq(output int nonFetch, output int mwCount);
    int s;
    logic mr, ill;
    logic [5:0] op;
    nonFetch = 0;
    mwCount  = 0;
    while (qState.size() > 0) begin
      s  = qState.pop_front();
      mr = qMr.pop_front();
      op = qOp.pop_front();
      ill = qIll.pop_front();
      Opcode   = op;
      MemReady = mr;
      @(negedge Clk);
      check("state", 32'(State), 32'(s));
      check($sformatf("outputs_s%0d", s), 32'(dutVec), 32'(expOut(s, mr)));
      check("illegal", 32'(IllegalOp), 32'(illExp));
      if (State != 4'd0) nonFetch++;
      if (MemWrite) mwCount++;
      @(posedge Clk);
      #1;
      if (ill) illExp = 1'b1;
    end
  endtask

  task automatic doReset();
    Rst_n    = 1'b0;
    MemReady = 1'b0;
    @(posedge Clk);
    #1;
    Rst_n  = 1'b1;
    illExp = 1'b0;
  endtask

  typedef struct {
    logic [5:0] op;
    int         fs;
    int         ms;
    int         expCycles;
    int         expMw;
  } vecT;

  vecT tbl[10];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    int nf, mwc, pick, fs, ms;
    logic [5:0] op;
    logic [5:0] legalOps[6];
    logic sawRw;

    legalOps = '{LW, SW, RT, BEQ, ADDI, JMP};
    tbl[0] = '{LW,   0, 0, 5, 0};
    tbl[1] = '{SW,   0, 3, 4, 1};
    tbl[2] = '{RT,   0, 0, 4, 0};
    tbl[3] = '{BEQ,  0, 0, 3, 0};
    tbl[4] = '{ADDI, 1, 0, 4, 0};
    tbl[5] = '{JMP,  0, 0, 3, 0};
    tbl[6] = '{LW,   2, 2, 5, 0};
    tbl[7] = '{BAD,  0, 0, 2, 0};
    tbl[8] = '{LW,   0, 0, 5, 0};
    tbl[9] = '{SW,   0, 0, 4, 1};

    // Reset values while in reset with MemReady high
    Rst_n = 1'b0; MemReady = 1'b1; Opcode = 6'h00; illExp = 1'b0;
    #2;
    check("rst_state",   32'(State), 32'd0);
    check("rst_iord",    32'(IorD), 32'd0);
    check("rst_alusrcb", 32'(ALUSrcB), 32'd1);
    check("rst_irwrite", 32'(IRWrite), 32'd1);
    check("rst_pcwrite", 32'(PCWrite), 32'd1);
    check("rst_illegal", 32'(IllegalOp), 32'd0);
    check("rst_branch",  32'(Branch), 32'd0);
    doReset();

    // Vector table: per-cycle model plus DUT-measured length and write pulses
    for (int i = 0; i < 10; i++) begin
      buildSeq(tbl[i].op, tbl[i].fs, tbl[i].ms);
      runSeq(nf, mwc);
      check($sformatf("len_vec%0d", i), 32'(nf), 32'(tbl[i].expCycles - 1 + tbl[i].ms));
      check($sformatf("memwrite_pulses_vec%0d", i), 32'(mwc), 32'(tbl[i].expMw));
    end

    // Sticky flag clears only on reset
    check("illegal_sticky", 32'(IllegalOp), 32'd1);
    doReset();
    check("illegal_cleared", 32'(IllegalOp), 32'd0);

    // Reset in the middle of a stalled load: immediate FETCH, no register write
    Opcode = LW; MemReady = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge Clk);
      #1;
    end
    MemReady = 1'b0;
    @(negedge Clk);
    check("midrd_state_before", 32'(State), 32'd3);
    #2;
    Rst_n = 1'b0;
    #1;
    check("midrd_async_state", 32'(State), 32'd0);
    check("midrd_async_regwrite", 32'(RegWrite), 32'd0);
    @(posedge Clk);
    @(negedge Clk);
    Rst_n = 1'b1;
    sawRw = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge Clk);
      if (RegWrite) sawRw = 1'b1;
    end
    check("midrd_after_state", 32'(State), 32'd0);
    check("midrd_no_regwrite", 32'(sawRw), 32'd0);
    @(posedge Clk);
    #1;
    illExp = 1'b0;

    // Randomized instruction stream with stalls and junk opcodes
    for (int n = 0; n < 40; n++) begin
      pick = $urandom_range(0, 7);
      if (pick < 6) op = legalOps[pick];
      else begin
        op = junkOp();
        while ((op == LW) || (op == SW) || (op == RT) || (op == BEQ) || (op == ADDI) || (op == JMP))
          op = junkOp();
      end
      fs = $urandom_range(0, 2);
      ms = $urandom_range(0, 3);
      buildSeq(op, fs, ms);
      runSeq(nf, mwc);
      check("rand_memwrite_pulses", 32'(mwc), (op == SW) ? 32'd1 : 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Moore-style main controller FSM for the multicycle MIPS datapath.
- Sequences fetch, decode, execute, memory and writeback for lw, sw, R-type, beq, addi and j.
- Produces every datapath enable and select. Raises Branch during the beq compare cycle; the datapath's AndGate combines it with ALU Zero to form the conditional PC enable.
- Holds in memory-access states until the memory handshake completes.

Parameters:
OP_RTYPE, 6'h00, R-type opcode
OP_LW, 6'h23, load word opcode
OP_SW, 6'h2B, store word opcode
OP_BEQ, 6'h04, branch-equal opcode
OP_ADDI, 6'h08, add-immediate opcode
OP_J, 6'h02, jump opcode

Ports:
Clk  input  1  system clock, rising edge
Rst_n  input  1  asynchronous active-low reset
Opcode  input  6  IR[31:26], valid from DECODE onward
MemReady  input  1  memory handshake; access completes on a cycle where it is high
IorD  output  1  0 = PC addresses memory, 1 = ALUOut does
MemRead  output  1  memory read request
MemWrite  output  1  memory write strobe
IRWrite  output  1  load instruction register
RegDst  output  1  1 = rd, 0 = rt
MemtoReg  output  1  1 = MDR, 0 = ALUOut to register file
RegWrite  output  1  register file write enable
ALUSrcA  output  1  0 = PC, 1 = register A
ALUSrcB  output  2  00 = B, 01 = const 4, 10 = sign-ext imm, 11 = imm<<2
ALUOp  output  2  00 add, 01 sub, 10 funct-decoded
PCSrc  output  2  00 ALU result, 01 ALUOut, 10 jump target
PCWrite  output  1  unconditional PC write
Branch  output  1  conditional PC write request (to AndGate)
IllegalOp  output  1  sticky: unsupported opcode decoded
State  output  4  current state encoding, for debug

Behaviour:
- States (4-bit encodings): FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11.
- Reset: async on Rst_n low. State is FETCH and IllegalOp is 0. Outputs are the FETCH decode; all signals not listed for FETCH are 0. Reset mid-instruction abandons it immediately; no partial write may follow reset release.
- Default for every output in every state is 0 unless listed below.
- FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSrc=00.
  - IRWrite = PCWrite = MemReady (combinational).
  - Stay while MemReady=0. Go to DECODE on MemReady=1.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00 (branch target into ALUOut). Next state by Opcode:
  - LW or SW -> MEMADR
  - RTYPE -> EXEC
  - BEQ -> BRANCH
  - ADDI -> ADDIEX
  - J -> JUMP
  - any other opcode -> FETCH, and set IllegalOp=1 (cleared only by reset).
- MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Next state MEMRD for LW, MEMWR for SW.
- MEMRD: MemRead=1, IorD=1. Hold while MemReady=0; go to MEMWB on MemReady=1.
- MEMWB: RegDst=0, MemtoReg=1, RegWrite=1. Next FETCH.
- MEMWR: IorD=1, MemWrite = MemReady. Hold while MemReady=0; go to FETCH on MemReady=1. Exactly one MemWrite pulse per sw.
- EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=10. Next ALUWB.
- ALUWB: RegDst=1, MemtoReg=0, RegWrite=1. Next FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCSrc=01, Branch=1. Next FETCH. Branch must never be high in any other state.
- ADDIEX: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Next ADDIWB.
- ADDIWB: RegDst=0, MemtoReg=0, RegWrite=1. Next FETCH.
- JUMP: PCSrc=10, PCWrite=1. Next FETCH.
- Opcode is sampled only in DECODE and MEMADR; changes at other times are ignored.
- Cycle counts with MemReady held high: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3. Each cycle of MemReady=0 in FETCH, MEMRD or MEMWR adds one cycle.
- Outputs are pure functions of State plus MemReady; no output depends on Opcode.
- Unused state encodings 12-15 go to FETCH on the next edge, with all outputs 0.

Decomposition:
- Shared package `mips_ctrl_pkg` holds:
  - opcode constants
  - state encodings (localparams)
  - ALUSrcB, ALUOp and PCSrc select codes
- The datapath ALU control uses the same codes.
- One sub-module is natural: `control_output_decode`, a combinational State+MemReady -> output-vector decoder. The parent module holds the state register, next-state logic and the IllegalOp flag.

Test Plan:
- Reset pulse, MemReady=1 -> State=0, IorD=0, ALUSrcB=01, IRWrite=1, PCWrite=1, IllegalOp=0, Branch=0.
- lw (Opcode=6'h23), MemReady=1 -> states 0,1,2,3,4,0. RegWrite=1 and MemtoReg=1 only in state 4.
- sw with MemReady low for 3 cycles in MEMWR -> MemWrite stays 0 for 3 cycles, then a single 1-cycle pulse, then FETCH. Total 7 cycles.
- beq (6'h04) -> states 0,1,8,0. Branch=1, ALUOp=01 and PCSrc=01 only in state 8; PCWrite=0 in state 8.
- Opcode=6'h3F in DECODE -> next state FETCH, IllegalOp=1 and stays 1 through following instructions until Rst_n pulse.
- Rst_n asserted mid-MEMRD (state 3) -> State=0 asynchronously, before the next clock edge. No RegWrite ever occurs for that load.
